aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_rcon_step.sv | 11 +
 rtl/aes_round_ctrl.sv | 96 +++++++++
 tb/tb_aes_round_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 round controller.
package aes_pkg;

  localparam int         AES_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] RCON_POLY  = 8'h1B;
  localparam logic [3:0] ROUND_LAST = 4'(AES_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_VALID = 2'd3
  } state_t;

endpackage

// File: rtl/aes_rcon_step.sv
// Combinational GF(2^8) xtime: next AES round constant from the current one.
module aes_rcon_step
  import aes_pkg::*;
(
  input  logic [7:0] rcon_in,
  output logic [7:0] rcon_out
);

  assign rcon_out = {rcon_in[6:0], 1'b0} ^ (rcon_in[7] ? RCON_POLY : 8'h00);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer: LOAD, ten rounds, then hold the result until accepted.
// Handshake: o_fValid stays high in VALID until a cycle with i_fReady=1; that cycle is the transfer.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic       i_fAbort,
  input  logic       i_fReady,
  output logic       o_fLoad,
  output logic       o_fRoundEn,
  output logic       o_fLastRound,
  output logic [3:0] o_Round,
  output logic [7:0] o_Rcon,
  output logic       o_fBusy,
  output logic       o_fValid,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d, rcon_next;

  aes_rcon_step u_rcon_step (
    .rcon_in  (rcon_q),
    .rcon_out (rcon_next)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Abort overrides everything; start is only looked at in IDLE and on the VALID transfer.
  always_comb begin
    state_d = state_q;
    if (i_fAbort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_fStart) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_ROUND;
        ST_ROUND: if (round_q == ROUND_LAST) state_d = ST_VALID;
        ST_VALID: if (i_fReady) state_d = i_fStart ? ST_LOAD : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    round_d = 4'd0;
    rcon_d  = RCON_INIT;
    if (state_d == ST_ROUND) begin
      if (state_q == ST_ROUND) begin
        round_d = round_q + 4'd1;
        rcon_d  = rcon_next;
      end else begin
        round_d = 4'd1;
      end
    end
  end

  always_comb begin
    o_fLoad      = 1'b0;
    o_fRoundEn   = 1'b0;
    o_fLastRound = 1'b0;
    o_Round      = 4'd0;
    o_Rcon       = RCON_INIT;
    o_fBusy      = 1'b0;
    o_fValid     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        o_fLoad = 1'b1;
        o_fBusy = 1'b1;
      end
      ST_ROUND: begin
        o_fRoundEn   = 1'b1;
        o_fLastRound = (round_q == ROUND_LAST);
        o_Round      = round_q;
        o_Rcon       = rcon_q;
        o_fBusy      = 1'b1;
      end
      ST_VALID: o_fValid = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against a phase-counting reference model.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic       load, round_en, last_round, busy, valid;
  logic [3:0] round;
  logic [7:0] rcon;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  // Model phase: -1 idle, 0 load, 1..10 round number, 11 result waiting.
  int phase = -1;
  logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_fStart     (start),
    .i_fAbort     (abort),
    .i_fReady     (ready),
    .o_fLoad      (load),
    .o_fRoundEn   (round_en),
    .o_fLastRound (last_round),
    .o_Round      (round),
    .o_Rcon       (rcon),
    .o_fBusy      (busy),
    .o_fValid     (valid),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (phase %0d, t=%0t)", tag, obs, exp, phase, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_rcon;
    logic [3:0] e_round;
    e_round = (phase >= 1 && phase <= 10) ? 4'(phase) : 4'd0;
    e_rcon  = (phase >= 1 && phase <= 10) ? rcon_tbl[phase-1] : 8'h01;
    check({tag, ".load"},  {7'd0, load},       {7'd0, phase == 0});
    check({tag, ".rnden"}, {7'd0, round_en},   {7'd0, phase >= 1 && phase <= 10});
    check({tag, ".last"},  {7'd0, last_round}, {7'd0, phase == 10});
    check({tag, ".round"}, {4'd0, round},      {4'd0, e_round});
    check({tag, ".rcon"},  rcon,               e_rcon);
    check({tag, ".busy"},  {7'd0, busy},       {7'd0, phase >= 0 && phase <= 10});
    check({tag, ".valid"}, {7'd0, valid},      {7'd0, phase == 11});
  endtask

  task automatic model_edge();
    if (!rst || abort) phase = -1;
    else if (phase == -1) phase = start ? 0 : -1;
    else if (phase <= 10) phase = phase + 1;
    else if (ready) phase = start ? 0 : -1;
  endtask

  // One clock: drive inputs, take the edge, advance the model, check off-edge.
  task automatic cyc(input logic s, input logic a, input logic r, input string tag);
    start = s; abort = a; ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run_to_phase(input int target, input logic s, input logic r, input string tag);
    int n = 0;
    while (phase != target && n < 40) begin
      cyc(s, 1'b0, r, tag);
      n++;
    end
    checks++;
    assert (phase == target) else begin
      errors++;
      $error("FAIL %s.timeout: got phase %0d expected %0d", tag, phase, target);
    end
  endtask

  initial begin
    int valid_cycles;
    #3;
    check_all("reset");
    @(posedge clk); #1; check_all("reset_hold");
    rst = 1'b1;
    cyc(0, 0, 0, "idle");

    // Single run, consumer always ready.
    cyc(1, 0, 1, "start");
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, "run_rdy");
    check_all("back_idle");

    // Consumer stalls 5 cycles after valid.
    cyc(1, 0, 0, "start2");
    run_to_phase(11, 0, 0, "to_valid");
    valid_cycles = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, "stall");
      if (valid) valid_cycles++;
    end
    check("valid_len", 8'(valid_cycles), 8'd6);
    cyc(0, 0, 1, "accept");
    check_all("idle_after_accept");

    // Back-to-back: start on the transfer cycle.
    cyc(1, 0, 0, "start3");
    run_to_phase(11, 0, 0, "to_valid3");
    cyc(1, 0, 1, "b2b");
    run_to_phase(11, 0, 0, "second_run");
    cyc(0, 0, 1, "accept3");

    // Abort at round 5.
    cyc(1, 0, 0, "start4");
    run_to_phase(5, 0, 0, "to_r5");
    cyc(0, 1, 0, "abort");
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, "post_abort");

    // Asynchronous reset at round 7.
    cyc(1, 0, 0, "start5");
    run_to_phase(7, 0, 0, "to_r7");
    #2 rst = 1'b0;
    phase = -1;
    #1 check_all("async_rst");
    cyc(0, 0, 1, "rst_low");
    rst = 1'b1;
    for (int i = 0; i < 13; i++) cyc(0, 0, 1, "post_rst");
    cyc(1, 0, 0, "start6");
    run_to_phase(11, 0, 0, "full_after_rst");
    cyc(0, 0, 1, "accept6");

    // Start held through the rounds must not restart.
    cyc(1, 0, 0, "start7");
    run_to_phase(10, 1, 0, "start_held");
    cyc(1, 0, 0, "held_valid");
    cyc(0, 0, 1, "accept7");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0),
          1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
